// File: rtl/pipe_stage_if.sv
// Handshake/control bundle between an elastic-pipe sequencer and its environment.
// Valid/ready: an item moves on a clock edge only when both valid and ready are high at that edge.
interface pipe_stage_if #(
    parameter int STAGES = 4
);
    localparam int CW = $clog2(STAGES + 1);

    logic              InValid;
    logic              InReady;
    logic              OutValid;
    logic              OutReady;
    logic              Hold;
    logic              Flush;
    logic              Drain;
    logic              DrainDone;
    logic [STAGES-1:0] En;
    logic [STAGES-1:0] Clr;
    logic [STAGES-1:0] Valid;
    logic [CW-1:0]     Count;
    logic [1:0]        state_dbg;

    modport master (
        output InValid, OutReady, Hold, Flush, Drain,
        input  InReady, OutValid, DrainDone, En, Clr, Valid, Count, state_dbg
    );

    modport slave (
        input  InValid, OutReady, Hold, Flush, Drain,
        output InReady, OutValid, DrainDone, En, Clr, Valid, Count, state_dbg
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Elastic-pipeline sequencer: per-stage valid tracking, bubble collapse, backpressure,
// flush, global hold and a drain handshake. Drives enable/clear of external stage registers.
module pipe_stage_ctrl #(
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         reset,
    pipe_stage_if.slave bus
);
    localparam int CW = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        DRAINED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [CW-1:0]     count_q, count_d;
    logic              drain_done_q, drain_done_d;

    logic              gate;
    logic              room;
    logic              in_ready;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    always_comb begin
        gate = bus.Hold | bus.Flush | reset;
        // room tracks (~Valid[i+1] | Adv[i+1]) walking from the output end backwards
        room = bus.OutReady;
        adv  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = valid_q[i] & room & ~gate;
            room   = room | ~valid_q[i];
        end

        in_ready = ~gate & ~bus.Drain & room &
                   ((state_q == IDLE) | (state_q == RUN));

        ld = {adv[STAGES-2:0], bus.InValid & in_ready};

        if (bus.Flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            valid_d = ld | (valid_q & ~adv);
            count_d = count_q + CW'(ld[0]) - CW'(adv[STAGES-1]);
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (bus.Drain) begin
                    if (count_q == '0) begin
                        drain_done_d = 1'b1;
                        state_d      = DRAINED;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (count_d != '0) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // A flush empties the pipe at once, so it also completes the drain
                if ((count_q == '0) || bus.Flush) begin
                    drain_done_d = 1'b1;
                    state_d      = bus.Drain ? DRAINED : IDLE;
                end
            end
            DRAINED: begin
                if (!bus.Drain) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            count_q      <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign bus.InReady   = in_ready;
    assign bus.OutValid  = valid_q[STAGES-1];
    assign bus.En        = ld;
    assign bus.Clr       = {STAGES{reset | bus.Flush}};
    assign bus.Valid     = valid_q;
    assign bus.Count     = count_q;
    assign bus.DrainDone = drain_done_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed scenarios plus a random run, with a shadow data
// pipeline moved by En/Clr and an expected queue of accepted items.
module tb_pipe_stage_ctrl;
    localparam int S = 4;

    logic clk;
    logic reset;
    logic [7:0] in_data;

    pipe_stage_if #(.STAGES(S)) bus ();

    pipe_stage_ctrl #(.STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int accepts = 0;
    int exits = 0;
    int cnt_m = 0;
    logic [7:0] exp_q[$];
    logic [7:0] dm [S];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string tag, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (bus.Count == '0) break;
            tick();
        end
        check(tag, bus.Count, 0);
    endtask

    // Scoreboard: accepted items pushed, exiting items popped and compared with the shadow pipe
    always @(negedge clk) begin
        logic acc, ext;
        acc = bus.InValid & bus.InReady;
        ext = bus.OutValid & bus.OutReady & ~bus.Hold & ~bus.Flush;
        if (reset) begin
            exp_q.delete();
            cnt_m <= 0;
        end else begin
            check("count_model", bus.Count, cnt_m);
            check("count_popcount", bus.Count, $countones(bus.Valid));
            check("outvalid_last", bus.OutValid, bus.Valid[S-1]);
            if (bus.Flush) begin
                exp_q.delete();
                cnt_m <= 0;
            end else begin
                if (ext) begin
                    tests++;
                    assert (exp_q.size() != 0) else begin
                        fails++;
                        $error("FAIL exit_empty_queue observed=exit expected=none");
                    end
                    if (exp_q.size() != 0) check("exit_data", dm[S-1], exp_q.pop_front());
                    exits <= exits + 1;
                end
                if (acc) begin
                    exp_q.push_back(in_data);
                    accepts <= accepts + 1;
                end
                cnt_m <= cnt_m + int'(acc) - int'(ext);
            end
        end
        for (int i = 0; i < S; i++) begin
            if (bus.Clr[i]) dm[i] <= '0;
            else if (bus.En[i]) dm[i] <= (i == 0) ? in_data : dm[(i == 0) ? 0 : i - 1];
        end
    end

    initial begin
        int sent, a0, e0, zero_k, done_k, pulses;
        reset = 1'b1;
        bus.InValid = 1'b0; bus.OutReady = 1'b0; bus.Hold = 1'b0;
        bus.Flush = 1'b0; bus.Drain = 1'b0; in_data = '0;
        tick(); tick();
        check("rst_clr", bus.Clr, 4'b1111);
        check("rst_en", bus.En, 0);
        check("rst_inready", bus.InReady, 0);
        reset = 1'b0;
        tick();
        check("rst_valid", bus.Valid, 0);
        check("rst_count", bus.Count, 0);
        check("rst_state", bus.state_dbg, 0);
        check("rst_draindone", bus.DrainDone, 0);
        check("rst_clr_low", bus.Clr, 0);
        check("rst_inready_up", bus.InReady, 1);

        // T1: single item latency
        bus.InValid = 1'b1; in_data = 8'hA1; bus.OutReady = 1'b1; #1;
        check("t1_inready", bus.InReady, 1);
        check("t1_en", bus.En, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.InValid = 1'b0;
            check($sformatf("t1_outvalid_%0d", k), bus.OutValid, (k == 4) ? 1 : 0);
        end
        check("t1_count_before_exit", bus.Count, 1);
        tick();
        check("t1_count_after", bus.Count, 0);
        check("t1_state_idle", bus.state_dbg, 0);

        // T2: fill to full with no consumer, then stream out
        bus.OutReady = 1'b0; sent = 0;
        for (int k = 0; k < 6; k++) begin
            bus.InValid = 1'b1; in_data = 8'(8'h10 + sent); #1;
            if (bus.InReady) sent++;
            tick();
        end
        check("t2_accepts_full", sent, 4);
        check("t2_valid_full", bus.Valid, 4'b1111);
        check("t2_count_full", bus.Count, 4);
        check("t2_inready_full", bus.InReady, 0);
        bus.OutReady = 1'b1; e0 = exits;
        for (int k = 0; k < 40; k++) begin
            if (sent < 10) begin
                bus.InValid = 1'b1; in_data = 8'(8'h10 + sent);
            end else begin
                bus.InValid = 1'b0;
            end
            #1;
            if (bus.InValid && bus.InReady) sent++;
            tick();
            if (sent == 10 && bus.Count == '0) break;
        end
        bus.InValid = 1'b0;
        check("t2_sent", sent, 10);
        check("t2_exits", exits - e0, 10);

        // T3: bubble collapse with items at stages 0 and 2
        bus.OutReady = 1'b0;
        bus.InValid = 1'b1; in_data = 8'h31; tick();
        bus.InValid = 1'b0; tick();
        bus.InValid = 1'b1; in_data = 8'h32; tick();
        bus.InValid = 1'b0;
        check("t3_valid_0101", bus.Valid, 4'b0101);
        tick();
        check("t3_valid_1010", bus.Valid, 4'b1010);
        tick();
        check("t3_valid_1100", bus.Valid, 4'b1100);
        tick();
        check("t3_valid_hold", bus.Valid, 4'b1100);
        bus.OutReady = 1'b1;
        wait_empty("t3_empty", 20);

        // T4: flush overrides hold
        bus.OutReady = 1'b0;
        bus.InValid = 1'b1; in_data = 8'h41; tick();
        in_data = 8'h42; tick();
        in_data = 8'h43; tick();
        bus.InValid = 1'b0;
        check("t4_count3", bus.Count, 3);
        bus.Flush = 1'b1; bus.Hold = 1'b1; #1;
        check("t4_clr", bus.Clr, 4'b1111);
        check("t4_en", bus.En, 0);
        check("t4_inready", bus.InReady, 0);
        tick();
        bus.Flush = 1'b0; bus.Hold = 1'b0; #1;
        check("t4_valid", bus.Valid, 0);
        check("t4_count", bus.Count, 0);
        check("t4_state", bus.state_dbg, 0);

        // T5: drain with two in flight, upstream still offering
        bus.OutReady = 1'b0;
        bus.InValid = 1'b1; in_data = 8'h51; tick();
        in_data = 8'h52; tick();
        check("t5_count2", bus.Count, 2);
        bus.Drain = 1'b1; bus.OutReady = 1'b1; in_data = 8'h5F;
        a0 = accepts; e0 = exits; zero_k = -1; done_k = -1; #1;
        check("t5_inready_drain", bus.InReady, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            bus.Drain = 1'b0;
            if (zero_k < 0 && bus.Count == '0) zero_k = k;
            if (bus.DrainDone) begin
                done_k = k;
                break;
            end
        end
        bus.InValid = 1'b0;
        check("t5_no_accepts", accepts - a0, 0);
        check("t5_exits", exits - e0, 2);
        check("t5_done_delay", done_k, zero_k + 1);
        tick();
        check("t5_done_pulse", bus.DrainDone, 0);
        wait_empty("t5_empty", 20);

        // Drain from empty IDLE
        bus.Drain = 1'b1; #1;
        check("t5_idle_pre", bus.DrainDone, 0);
        tick();
        bus.Drain = 1'b0;
        check("t5_idle_done", bus.DrainDone, 1);
        tick();
        check("t5_idle_done_low", bus.DrainDone, 0);
        check("t5_idle_state", bus.state_dbg, 0);

        // Drain held high: single pulse, no re-accept
        bus.Drain = 1'b1; bus.InValid = 1'b1; in_data = 8'h61; a0 = accepts; pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.DrainDone) pulses++;
        end
        bus.Drain = 1'b0; bus.InValid = 1'b0;
        check("t5_held_pulses", pulses, 1);
        tick();
        check("t5_held_accepts", accepts - a0, 0);
        check("t5_held_state", bus.state_dbg, 0);

        // T6: random traffic with a mid-stream reset
        for (int k = 0; k < 10000; k++) begin
            bus.InValid  = 1'($urandom_range(0, 1));
            bus.OutReady = 1'($urandom_range(0, 1));
            bus.Hold     = ($urandom_range(0, 7) == 0);
            bus.Flush    = ($urandom_range(0, 299) == 0);
            in_data      = 8'($urandom_range(0, 255));
            reset        = (k == 5000);
            tick();
            if (k == 5000) begin
                check("t6_reset_valid", bus.Valid, 0);
                check("t6_reset_count", bus.Count, 0);
            end
        end
        reset = 1'b0; bus.InValid = 1'b0; bus.Hold = 1'b0; bus.Flush = 1'b0;
        bus.OutReady = 1'b1;
        wait_empty("t6_empty", 20);
        tick();
        check("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
